// File: rtl/music_sequencer.sv
// Melody sequencer for the buzzer: steps a note ROM at a fixed beat rate and
// emits a 6-bit note index (0 = rest). Looping background tune plus a one-shot jingle.
module music_sequencer #(
    parameter int BEAT_CYCLES = 3_125_000,
    parameter int GAP_CYCLES  = 312_500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_play,
    input  logic       i_gameover,
    input  logic       i_mute,
    output logic [5:0] o_music_scale,
    output logic       o_busy,
    output logic       o_song_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        NOTE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SONG_BGM    = 1'b0;
    localparam logic SONG_JINGLE = 1'b1;

    localparam logic [31:0] BEAT_W = 32'(BEAT_CYCLES);
    localparam logic [27:0] GAP_W  = 28'(GAP_CYCLES);

    state_t      state_q, state_d;
    logic        song_q, song_d;
    logic [3:0]  idx_q, idx_d;
    logic [27:0] note_cnt_q, note_cnt_d;
    logic [5:0]  note_q, note_d;
    logic [5:0]  scale_q, scale_d;
    logic        song_end_q, song_end_d;
    logic        gameover_q;
    logic        armed_q;

    logic        go_edge;
    logic [9:0]  entry;
    logic [5:0]  entry_note;
    logic [3:0]  entry_dur;

    // Entry = {note, dur}; dur == 0 marks the end of a song.
    function automatic logic [9:0] rom_lookup(input logic song, input logic [3:0] idx);
        logic [9:0] e;
        e = 10'd0;
        if (song == SONG_BGM) begin
            case (idx)
                4'd0:    e = {6'd8,  4'd4};
                4'd1:    e = {6'd10, 4'd4};
                4'd2:    e = {6'd12, 4'd4};
                4'd3:    e = {6'd10, 4'd4};
                4'd4:    e = {6'd8,  4'd4};
                4'd5:    e = {6'd12, 4'd4};
                4'd6:    e = {6'd15, 4'd8};
                4'd7:    e = {6'd0,  4'd4};
                default: e = 10'd0;
            endcase
        end else begin
            case (idx)
                4'd0:    e = {6'd12, 4'd2};
                4'd1:    e = {6'd11, 4'd2};
                4'd2:    e = {6'd10, 4'd2};
                4'd3:    e = {6'd8,  4'd8};
                default: e = 10'd0;
            endcase
        end
        return e;
    endfunction

    always_comb begin
        // armed_q blocks a false edge when i_gameover is already high as reset releases.
        go_edge    = i_gameover & ~gameover_q & armed_q;
        entry      = rom_lookup(song_q, idx_q);
        entry_note = entry[9:4];
        entry_dur  = entry[3:0];

        state_d    = state_q;
        song_d     = song_q;
        idx_d      = idx_q;
        note_cnt_d = note_cnt_q;
        note_d     = note_q;
        scale_d    = 6'd0;
        song_end_d = 1'b0;

        if (go_edge) begin
            state_d = FETCH;
            song_d  = SONG_JINGLE;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_play && !i_gameover) begin
                        state_d = FETCH;
                        song_d  = SONG_BGM;
                        idx_d   = 4'd0;
                    end
                end
                FETCH: begin
                    if (song_q == SONG_BGM && !i_play) begin
                        state_d    = IDLE;
                        idx_d      = 4'd0;
                        note_cnt_d = 28'd0;
                    end else if (entry_dur != 4'd0) begin
                        note_cnt_d = 28'(32'(entry_dur) * BEAT_W - 32'd1);
                        note_d     = entry_note;
                        state_d    = NOTE;
                    end else begin
                        song_end_d = 1'b1;
                        if (song_q == SONG_BGM) begin
                            idx_d = 4'd0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                NOTE: begin
                    if (song_q == SONG_BGM && !i_play) begin
                        state_d    = IDLE;
                        idx_d      = 4'd0;
                        note_cnt_d = 28'd0;
                    end else begin
                        // The tail of every note is silent so repeated pitches re-articulate.
                        if (!i_mute && note_cnt_q >= GAP_W) begin
                            scale_d = note_q;
                        end
                        if (note_cnt_q == 28'd0) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = FETCH;
                        end else begin
                            note_cnt_d = note_cnt_q - 28'd1;
                        end
                    end
                end
                DONE: begin
                    if (!i_gameover) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            song_q     <= SONG_BGM;
            idx_q      <= 4'd0;
            note_cnt_q <= 28'd0;
            note_q     <= 6'd0;
            scale_q    <= 6'd0;
            song_end_q <= 1'b0;
            gameover_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            idx_q      <= idx_d;
            note_cnt_q <= note_cnt_d;
            note_q     <= note_d;
            scale_q    <= scale_d;
            song_end_q <= song_end_d;
            gameover_q <= i_gameover;
            armed_q    <= 1'b1;
        end
    end

    assign o_music_scale = scale_q;
    assign o_busy        = (state_q != IDLE);
    assign o_song_end    = song_end_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a short beat: expected output streams are
// built as segments of constant {scale, busy, song_end} from the bench's own melody tables.
module tb_music_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_play;
    logic       i_gameover;
    logic       i_mute;
    logic [5:0] o_music_scale;
    logic       o_busy;
    logic       o_song_end;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       play;
        logic       go;
        logic       mute;
        int         cycles;
        logic [5:0] scale;
        logic       busy;
        logic       send;
        string      name;
    } seg_t;

    seg_t segs[$];

    int bgm_note[8] = '{8, 10, 12, 10, 8, 12, 15, 0};
    int bgm_dur[8]  = '{4, 4, 4, 4, 4, 4, 8, 4};
    int jin_note[4] = '{12, 11, 10, 8};
    int jin_dur[4]  = '{2, 2, 2, 8};

    music_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_play       (i_play),
        .i_gameover   (i_gameover),
        .i_mute       (i_mute),
        .o_music_scale(o_music_scale),
        .o_busy       (o_busy),
        .o_song_end   (o_song_end)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic add(input logic p, input logic g, input logic m, input int n,
                       input int s, input logic b, input logic e, input string nm);
        seg_t sg;
        sg.play   = p;
        sg.go     = g;
        sg.mute   = m;
        sg.cycles = n;
        sg.scale  = 6'(s);
        sg.busy   = b;
        sg.send   = e;
        sg.name   = nm;
        segs.push_back(sg);
    endtask

    // One ROM entry: 1 fetch cycle, then dur*BEAT note cycles whose last GAP are silent.
    task automatic add_note(input logic p, input logic g, input logic m,
                            input int note, input int dur, input string nm);
        add(p, g, m, 1, 0, 1'b1, 1'b0, {nm, " fetch"});
        add(p, g, m, dur * BEAT - GAP, m ? 0 : note, 1'b1, 1'b0, $sformatf("%s %0d on", nm, note));
        add(p, g, m, GAP, 0, 1'b1, 1'b0, $sformatf("%s %0d gap", nm, note));
    endtask

    task automatic run_segs();
        foreach (segs[k]) begin
            logic ok;
            int   bad_cyc;
            logic [5:0] a_scale;
            logic a_busy, a_end;
            ok = 1'b1;
            bad_cyc = 0;
            a_scale = 6'd0;
            a_busy = 1'b0;
            a_end = 1'b0;
            i_play     = segs[k].play;
            i_gameover = segs[k].go;
            i_mute     = segs[k].mute;
            for (int c = 0; c < segs[k].cycles; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (ok && (o_music_scale !== segs[k].scale || o_busy !== segs[k].busy ||
                           o_song_end !== segs[k].send)) begin
                    ok = 1'b0;
                    bad_cyc = c;
                    a_scale = o_music_scale;
                    a_busy = o_busy;
                    a_end = o_song_end;
                end
            end
            n_checks++;
            if (ok) begin
                n_pass++;
                $display("seg %-22s cycles=%0d scale=%0d busy=%0b end=%0b ok",
                         segs[k].name, segs[k].cycles, segs[k].scale, segs[k].busy, segs[k].send);
            end else begin
                $display("FAIL seg %s at cycle %0d: got scale=%0d busy=%0b end=%0b, required scale=%0d busy=%0b end=%0b",
                         segs[k].name, bad_cyc, a_scale, a_busy, a_end,
                         segs[k].scale, segs[k].busy, segs[k].send);
            end
        end
        segs.delete();
    endtask

    task automatic check_now(input string nm, input int s, input logic b, input logic e);
        n_checks++;
        if (o_music_scale === 6'(s) && o_busy === b && o_song_end === e) begin
            n_pass++;
            $display("chk %-22s scale=%0d busy=%0b end=%0b ok", nm, o_music_scale, o_busy, o_song_end);
        end else begin
            $display("FAIL chk %s: got scale=%0d busy=%0b end=%0b, required scale=%0d busy=%0b end=%0b",
                     nm, o_music_scale, o_busy, o_song_end, s, b, e);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_play     = 1'b0;
        i_gameover = 1'b0;
        i_mute     = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset", 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        add(0, 0, 0, 5, 0, 1'b0, 1'b0, "idle");
        run_segs();

        // Full background loop, restart at note 8, then stop.
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "bgm start");
        for (int i = 0; i < 8; i++) add_note(1, 0, 0, bgm_note[i], bgm_dur[i], "bgm");
        add(1, 0, 0, 1, 0, 1'b1, 1'b1, "bgm end pulse");
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "bgm loop fetch");
        add(1, 0, 0, BEAT * 4 - GAP, 8, 1'b1, 1'b0, "bgm loop 8");
        add(0, 0, 0, 3, 0, 1'b0, 1'b0, "bgm stop");
        run_segs();

        // i_play drops mid note 10, then restarts from the top.
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "drop start");
        add_note(1, 0, 0, 8, 4, "drop");
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "drop fetch 10");
        add(1, 0, 0, 10, 10, 1'b1, 1'b0, "drop 10 part");
        add(0, 0, 0, 3, 0, 1'b0, 1'b0, "drop idle");
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "restart start");
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "restart fetch");
        add(1, 0, 0, BEAT * 4 - GAP, 8, 1'b1, 1'b0, "restart 8");
        add(0, 0, 0, 2, 0, 1'b0, 1'b0, "restart stop");
        run_segs();

        // Game-over mid note 12 aborts the tune and plays the jingle.
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "abort start");
        add_note(1, 0, 0, 8, 4, "abort");
        add_note(1, 0, 0, 10, 4, "abort");
        add(1, 0, 0, 1, 0, 1'b1, 1'b0, "abort fetch 12");
        add(1, 0, 0, 5, 12, 1'b1, 1'b0, "abort 12 part");
        add(1, 1, 0, 1, 0, 1'b1, 1'b0, "abort edge");
        for (int i = 0; i < 4; i++) add_note(1, 1, 0, jin_note[i], jin_dur[i], "jin");
        add(1, 1, 0, 1, 0, 1'b1, 1'b1, "jin end pulse");
        add(1, 1, 0, 5, 0, 1'b1, 1'b0, "jin done");
        add(0, 0, 0, 3, 0, 1'b0, 1'b0, "jin release");
        run_segs();

        // i_play and a game-over edge together from IDLE: the jingle wins.
        add(1, 1, 0, 1, 0, 1'b1, 1'b0, "both start");
        for (int i = 0; i < 4; i++) add_note(1, 1, 0, jin_note[i], jin_dur[i], "both");
        add(1, 1, 0, 1, 0, 1'b1, 1'b1, "both end pulse");
        add(1, 1, 0, 3, 0, 1'b1, 1'b0, "both done");
        add(0, 0, 0, 3, 0, 1'b0, 1'b0, "both release");
        run_segs();

        // Muted tune keeps exactly the unmuted timing.
        add(1, 0, 1, 1, 0, 1'b1, 1'b0, "mute start");
        for (int i = 0; i < 8; i++) add_note(1, 0, 1, bgm_note[i], bgm_dur[i], "mute");
        add(1, 0, 1, 1, 0, 1'b1, 1'b1, "mute end pulse");
        add(1, 0, 1, 20, 0, 1'b1, 1'b0, "mute loop");
        add(0, 0, 0, 3, 0, 1'b0, 1'b0, "mute stop");
        run_segs();

        // Asynchronous reset mid-jingle, then no jingle while i_gameover stays high.
        add(0, 1, 0, 1, 0, 1'b1, 1'b0, "rst jin start");
        add(0, 1, 0, 1, 0, 1'b1, 1'b0, "rst jin fetch");
        add(0, 1, 0, 5, 12, 1'b1, 1'b0, "rst jin 12 part");
        run_segs();
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        add(0, 1, 0, 5, 0, 1'b0, 1'b0, "held go no edge");
        add(0, 0, 0, 2, 0, 1'b0, 1'b0, "go low");
        add(0, 1, 0, 1, 0, 1'b1, 1'b0, "new edge start");
        add(0, 1, 0, 1, 0, 1'b1, 1'b0, "new edge fetch");
        add(0, 1, 0, 4, 12, 1'b1, 1'b0, "new edge 12");
        run_segs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
Upstream note source for the buzzer tone generator. Steps through a fixed melody ROM at a programmable tick rate and emits a 6-bit note index: 0 = rest, 1..21 = C_LOW..B_HIGH.
Plays a looping background tune while the game runs, and a one-shot game-over jingle when game-over asserts. An articulation gap separates consecutive notes so repeated pitches stay distinct.

Parameters:
BEAT_CYCLES, 3_125_000, clk cycles per duration tick (62.5 ms at 50 MHz); must be >= 2.
GAP_CYCLES, 312_500, silent cycles at the end of each non-rest note; must be < BEAT_CYCLES.

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous, active-low reset
i_play  input  1  level; 1 = run background tune
i_gameover  input  1  level; a rising edge starts the jingle, which has priority over the background tune
i_mute  input  1  level; forces o_music_scale to 0; sequencing continues
o_music_scale  output  6  note index to the buzzer, registered
o_busy  output  1  1 in any state other than IDLE
o_song_end  output  1  1-cycle pulse when an end marker is reached

Behaviour:
- ROM entry = {note[5:0], dur[3:0]}; dur 0 = end marker. Read combinationally by index.
- BGM table, idx 0..8: (8,4) (10,4) (12,4) (10,4) (8,4) (12,4) (15,8) (0,4) (end).
- JINGLE table, idx 0..4: (12,2) (11,2) (10,2) (8,8) (end).
- Reset values: all outputs 0, state IDLE, idx 0, counters 0, gameover edge register 0. Reset mid-note silences the output immediately.
- States: IDLE, FETCH, NOTE, DONE. A 1-bit song select chooses BGM or JINGLE.
- go_edge = i_gameover & ~i_gameover_d, where i_gameover_d is registered.
- IDLE transitions:
  - go_edge -> FETCH, song=JINGLE, idx=0.
  - else i_play & ~i_gameover -> FETCH, song=BGM, idx=0.
- FETCH (1 cycle, output 0):
  - dur != 0: load note_cnt = dur*BEAT_CYCLES - 1, latch note -> NOTE.
  - dur == 0, BGM: pulse o_song_end, idx=0, stay in FETCH (loop).
  - dur == 0, JINGLE: pulse o_song_end -> DONE.
- NOTE:
  - o_music_scale = note, except 0 when note_cnt < GAP_CYCLES, or when i_mute.
  - note_cnt decrements each cycle; at 0 -> idx+1 -> FETCH.
  - Total per entry = 1 + dur*BEAT_CYCLES cycles.
- DONE: output 0; stays until i_gameover == 0, then -> IDLE.
- go_edge in any state (FETCH/NOTE/DONE): abort, song=JINGLE, idx=0 -> FETCH next cycle. Highest priority after reset.
- i_play low while BGM is in FETCH/NOTE: -> IDLE next cycle, output 0, idx reset. The jingle ignores i_play.
- i_play and go_edge in the same cycle: the jingle wins.
- Output latency: o_music_scale is registered, so a value is visible one cycle after the state/counter that produces it.
- note_cnt width: 28 bits. dur*BEAT_CYCLES is computed in 32-bit and must not overflow (15*3_125_000 fits).
- o_song_end: exactly one cycle per end marker, never asserted in IDLE.

Test Plan:
- BEAT_CYCLES=10, GAP_CYCLES=2; reset, i_play=1 -> FETCH 1 cycle at 0; then 8 for 38 cycles, 0 for 2; then 10 ...; 15 held 78 cycles; rest 40 cycles; o_song_end pulse; loop restarts with 8.
- Same params, i_gameover rises mid-way through note 12 of BGM -> within 2 cycles the output is 0 for FETCH, then 12/11/10 (18 on + 2 off each) and 8 (78+2); o_song_end pulse; o_busy stays 1 in DONE until i_gameover drops, then 0.
- i_play=1 and i_gameover rising in the same cycle from IDLE -> jingle plays, not BGM.
- i_mute=1 during BGM -> o_music_scale 0 throughout; o_song_end still pulses after 1+8*(1+40)+... cycles, matching the unmuted timing exactly.
- i_play drops in the middle of note 10 -> output 0 and o_busy=0 next cycle; i_play re-asserts -> restart at idx 0 (note 8).
- rst_n pulsed low asynchronously mid-jingle -> all outputs 0 immediately; after release with i_gameover held 1, no jingle (no edge), stays IDLE.
